// File: rtl/io_mmio.sv
// Memory-mapped switch/LED/seven-segment peripheral: combinational reads, writes on the clock edge, always ready (no backpressure).
// IO_HEX_DECODE_EN: SEGk registers hold {blank, hex nibble} and are decoded to gfedcba; otherwise SEGk drives raw segments.
module io_mmio #(
  parameter logic [31:0] BASE_ADDR  = 32'h00001000,
  parameter int          SW_W       = 4,
  parameter int          LED_W      = 4,
  parameter int          NSEG       = 2,
  parameter int          DEB_CYCLES = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                we,
  input  logic [31:0]         a,
  input  logic [31:0]         wd,
  input  logic [2:0]          funct3,
  output logic [31:0]         rd,
  input  logic [SW_W-1:0]     switches,
  output logic [LED_W-1:0]    leds,
  output logic [NSEG*7-1:0]   seg,
  output logic                irq
);

  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);
`ifdef IO_HEX_DECODE_EN
  localparam int SEG_W = 5;
  localparam logic [SEG_W-1:0] SEG_RST = 5'b10000;
`else
  localparam int SEG_W = 7;
  localparam logic [SEG_W-1:0] SEG_RST = '0;
`endif

  logic [31:0]      off;
  logic [29:0]      idx;
  logic             aligned, f3_ok, wr_ok;
  logic             wr_led, wr_edge, wr_irq_en;
  logic [SW_W-1:0]  s1, s2, deb, fire, neq, rise, edge_q, irq_en, edge_clr;
  logic [CW-1:0]    cnt [SW_W];
  logic [LED_W-1:0] led_q;
  logic [SEG_W-1:0] seg_q [NSEG];
  logic             unused_bits;

  assign off       = a - BASE_ADDR;
  assign idx       = off[31:2];
  assign aligned   = (a[1:0] == 2'b00);
  assign f3_ok     = (funct3 == 3'b000) || (funct3 == 3'b001) || (funct3 == 3'b010);
  assign wr_ok     = we && aligned && f3_ok;
  assign wr_led    = wr_ok && (idx == 30'd1);
  assign wr_edge   = wr_ok && (idx == 30'd2);
  assign wr_irq_en = wr_ok && (idx == 30'd3);
  assign edge_clr  = wr_edge ? wd[SW_W-1:0] : '0;

  // A bit flips only after DEB_CYCLES consecutive cycles of disagreement with s2.
  always_comb begin
    neq  = s2 ^ deb;
    fire = '0;
    for (int i = 0; i < SW_W; i++) begin
      fire[i] = neq[i] && (cnt[i] == CNT_MAX);
    end
    rise = fire & s2;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1     <= '0;
      s2     <= '0;
      deb    <= '0;
      led_q  <= '0;
      edge_q <= '0;
      irq_en <= '0;
      for (int i = 0; i < SW_W; i++) cnt[i] <= '0;
      for (int k = 0; k < NSEG; k++) seg_q[k] <= SEG_RST;
    end else begin
      s1  <= switches;
      s2  <= s1;
      deb <= deb ^ fire;
      for (int i = 0; i < SW_W; i++) begin
        if (fire[i])     cnt[i] <= '0;
        else if (neq[i]) cnt[i] <= cnt[i] + 1'b1;
        else             cnt[i] <= '0;
      end
      // OR-ing rise after the clear lets a same-cycle set win.
      edge_q <= (edge_q & ~edge_clr) | rise;
      if (wr_led)    led_q  <= wd[LED_W-1:0];
      if (wr_irq_en) irq_en <= wd[SW_W-1:0];
      for (int k = 0; k < NSEG; k++) begin
        if (wr_ok && (idx == 30'(4 + k))) seg_q[k] <= wd[SEG_W-1:0];
      end
    end
  end

  always_comb begin
    rd = '0;
    if (aligned) begin
      if (idx == 30'd0) rd[SW_W-1:0]  = deb;
      if (idx == 30'd1) rd[LED_W-1:0] = led_q;
      if (idx == 30'd2) rd[SW_W-1:0]  = edge_q;
      if (idx == 30'd3) rd[SW_W-1:0]  = irq_en;
      for (int k = 0; k < NSEG; k++) begin
        if (idx == 30'(4 + k)) rd[SEG_W-1:0] = seg_q[k];
      end
    end
  end

`ifdef IO_HEX_DECODE_EN
  function automatic logic [6:0] hex7(input logic [3:0] h);
    case (h)
      4'h0: hex7 = 7'h3F;  4'h1: hex7 = 7'h06;  4'h2: hex7 = 7'h5B;  4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;  4'h5: hex7 = 7'h6D;  4'h6: hex7 = 7'h7D;  4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h6F;  4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;  4'hD: hex7 = 7'h5E;  4'hE: hex7 = 7'h79;  default: hex7 = 7'h71;
    endcase
  endfunction

  for (genvar k = 0; k < NSEG; k++) begin : g_seg
    assign seg[7*k +: 7] = seg_q[k][4] ? 7'd0 : hex7(seg_q[k][3:0]);
  end
`else
  for (genvar k = 0; k < NSEG; k++) begin : g_seg
    assign seg[7*k +: 7] = seg_q[k];
  end
`endif

  assign leds        = led_q;
  assign irq         = |(edge_q & irq_en);
  assign unused_bits = &{1'b0, wd, off[1:0]};

endmodule
